// File: rtl/parking_slot_ctrl.sv
// Parking slot sequencing controller: grants free slots, stores check-in times, releases slots and
// drives the barrier pulse. Define PARK_FEE_EN to add the saturating fee output.
module parking_slot_ctrl #(
  parameter int NSLOT    = 6,
  parameter int TW       = 11,
  parameter int GATE_CYC = 4,
  parameter int FEE_RATE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TW-1:0]    timer,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic [3:0]       exit_slot,
  output logic             entry_ack,
  output logic             entry_rej,
  output logic [3:0]       entry_slot,
  output logic             exit_ack,
  output logic             exit_err,
  output logic [TW-1:0]    elapsed,
  output logic [NSLOT-1:0] occupied,
  output logic             full,
  output logic             gate_open,
  output logic [15:0]      fee
);

  localparam int CW = $clog2(GATE_CYC + 1);

  typedef enum logic [1:0] {IDLE, ENTRY, EXIT, GATE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [NSLOT-1:0] occupied_q, occupied_d;
  logic [TW-1:0]    t_in_q [NSLOT];
  logic [TW-1:0]    t_in_d [NSLOT];
  logic [3:0]       entry_slot_q, entry_slot_d;
  logic [TW-1:0]    elapsed_q, elapsed_d;
  logic             entry_ack_q, entry_ack_d;
  logic             entry_rej_q, entry_rej_d;
  logic             exit_ack_q, exit_ack_d;
  logic             exit_err_q, exit_err_d;
  logic             gate_open_q, gate_open_d;

  logic [3:0]       free_id;
  logic             exit_hit;
  logic [TW-1:0]    exit_t_in;

  assign full = &occupied_q;

  // Lowest free slot id (0 when full) and lookup of the slot presented at the exit.
  always_comb begin
    free_id   = '0;
    exit_hit  = 1'b0;
    exit_t_in = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!occupied_q[i]) free_id = 4'(i + 1);
    end
    for (int i = 0; i < NSLOT; i++) begin
      if (exit_slot == 4'(i + 1)) begin
        exit_hit  = occupied_q[i];
        exit_t_in = t_in_q[i];
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    occupied_d   = occupied_q;
    t_in_d       = t_in_q;
    entry_slot_d = entry_slot_q;
    elapsed_d    = elapsed_q;
    entry_ack_d  = 1'b0;
    entry_rej_d  = 1'b0;
    exit_ack_d   = 1'b0;
    exit_err_d   = 1'b0;
    gate_open_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (exit_req)       state_d = EXIT;
        else if (entry_req) state_d = ENTRY;
      end
      ENTRY: begin
        if (!full) begin
          for (int i = 0; i < NSLOT; i++) begin
            if (free_id == 4'(i + 1)) begin
              occupied_d[i] = 1'b1;
              t_in_d[i]     = timer;
            end
          end
          entry_slot_d = free_id;
          entry_ack_d  = 1'b1;
          gate_cnt_d   = '0;
          state_d      = GATE;
        end else begin
          entry_rej_d = 1'b1;
          state_d     = IDLE;
        end
      end
      EXIT: begin
        if (exit_hit) begin
          // Modulo-2^TW subtraction absorbs a single timer wrap.
          elapsed_d = timer - exit_t_in;
          for (int i = 0; i < NSLOT; i++) begin
            if (exit_slot == 4'(i + 1)) occupied_d[i] = 1'b0;
          end
          exit_ack_d = 1'b1;
          gate_cnt_d = '0;
          state_d    = GATE;
        end else begin
          exit_err_d = 1'b1;
          state_d    = IDLE;
        end
      end
      GATE: begin
        gate_open_d = 1'b1;
        gate_cnt_d  = gate_cnt_q + CW'(1);
        if (gate_cnt_q == CW'(GATE_CYC - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      occupied_q   <= '0;
      // NOTE: the time store is reset explicitly because stored times are defined as 0 after reset.
      for (int i = 0; i < NSLOT; i++) t_in_q[i] <= '0;
      entry_slot_q <= '0;
      elapsed_q    <= '0;
      entry_ack_q  <= 1'b0;
      entry_rej_q  <= 1'b0;
      exit_ack_q   <= 1'b0;
      exit_err_q   <= 1'b0;
      gate_open_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      occupied_q   <= occupied_d;
      t_in_q       <= t_in_d;
      entry_slot_q <= entry_slot_d;
      elapsed_q    <= elapsed_d;
      entry_ack_q  <= entry_ack_d;
      entry_rej_q  <= entry_rej_d;
      exit_ack_q   <= exit_ack_d;
      exit_err_q   <= exit_err_d;
      gate_open_q  <= gate_open_d;
    end
  end

`ifdef PARK_FEE_EN
  logic [15:0]    fee_q, fee_d;
  logic [TW+15:0] fee_prod;

  always_comb begin
    fee_prod = (TW + 16)'(elapsed_d) * (TW + 16)'(FEE_RATE);
    fee_d    = fee_q;
    if (state_q == EXIT && exit_hit) begin
      fee_d = (|fee_prod[TW+15:16]) ? 16'hFFFF : fee_prod[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fee_q <= '0;
    else        fee_q <= fee_d;
  end

  assign fee = fee_q;
`else
  assign fee = 16'h0000;
`endif

  assign entry_ack  = entry_ack_q;
  assign entry_rej  = entry_rej_q;
  assign entry_slot = entry_slot_q;
  assign exit_ack   = exit_ack_q;
  assign exit_err   = exit_err_q;
  assign elapsed    = elapsed_q;
  assign occupied   = occupied_q;
  assign gate_open  = gate_open_q;

endmodule

// File: tb/tb_parking_slot_ctrl.sv
// Self-checking bench for parking_slot_ctrl: schedule-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_parking_slot_ctrl;

  localparam int NSLOT    = 6;
  localparam int TW       = 11;
  localparam int GATE_CYC = 4;
  localparam int FEE_RATE = 2;

  logic             clk;
  logic             rst_n;
  logic [TW-1:0]    timer;
  logic             entry_req;
  logic             exit_req;
  logic [3:0]       exit_slot;
  logic             entry_ack;
  logic             entry_rej;
  logic [3:0]       entry_slot;
  logic             exit_ack;
  logic             exit_err;
  logic [TW-1:0]    elapsed;
  logic [NSLOT-1:0] occupied;
  logic             full;
  logic             gate_open;
  logic [15:0]      fee;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_timer;

  parking_slot_ctrl #(
    .NSLOT(NSLOT), .TW(TW), .GATE_CYC(GATE_CYC), .FEE_RATE(FEE_RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .timer(timer),
    .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot),
    .entry_ack(entry_ack), .entry_rej(entry_rej), .entry_slot(entry_slot),
    .exit_ack(exit_ack), .exit_err(exit_err), .elapsed(elapsed),
    .occupied(occupied), .full(full), .gate_open(gate_open), .fee(fee)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a request seen while free is acted on at the following edge; a grant or
  // release holds the lot busy for the gate pulse plus one edge.
  int e, resume_e, pend, gate_left, ms;
  bit m_occ [1:NSLOT];
  int m_tin [1:NSLOT];
  int m_entry_slot, m_elapsed, m_fee;
  bit m_entry_ack, m_entry_rej, m_exit_ack, m_exit_err, m_gate;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0; resume_e = 0; pend = 0; gate_left = 0;
      for (int i = 1; i <= NSLOT; i++) begin m_occ[i] = 1'b0; m_tin[i] = 0; end
      m_entry_slot = 0; m_elapsed = 0; m_fee = 0;
      m_entry_ack = 0; m_entry_rej = 0; m_exit_ack = 0; m_exit_err = 0; m_gate = 0;
    end else begin
      e++;
      m_entry_ack = 0; m_entry_rej = 0; m_exit_ack = 0; m_exit_err = 0;
      m_gate = (gate_left > 0);
      if (gate_left > 0) gate_left--;
      if (pend == 1) begin
        ms = 0;
        for (int i = NSLOT; i >= 1; i--) if (!m_occ[i]) ms = i;
        if (ms != 0) begin
          m_occ[ms] = 1'b1; m_tin[ms] = int'(timer); m_entry_slot = ms; m_entry_ack = 1;
          gate_left = GATE_CYC; resume_e = e + GATE_CYC + 1;
        end else begin
          m_entry_rej = 1; resume_e = e + 1;
        end
        pend = 0;
      end else if (pend == 2) begin
        ms = int'(exit_slot);
        if (ms >= 1 && ms <= NSLOT && m_occ[ms]) begin
          m_elapsed = (int'(timer) - m_tin[ms]) & ((1 << TW) - 1);
`ifdef PARK_FEE_EN
          m_fee = (m_elapsed * FEE_RATE > 65535) ? 65535 : m_elapsed * FEE_RATE;
`endif
          m_occ[ms] = 1'b0; m_exit_ack = 1;
          gate_left = GATE_CYC; resume_e = e + GATE_CYC + 1;
        end else begin
          m_exit_err = 1; resume_e = e + 1;
        end
        pend = 0;
      end else if (e >= resume_e) begin
        if (exit_req)       pend = 2;
        else if (entry_req) pend = 1;
      end
    end
  end

  logic [NSLOT-1:0] exp_occ;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 1; i <= NSLOT; i++) exp_occ[i-1] = m_occ[i];
      check("cyc entry_ack",  32'(entry_ack),  32'(m_entry_ack));
      check("cyc entry_rej",  32'(entry_rej),  32'(m_entry_rej));
      check("cyc entry_slot", 32'(entry_slot), 32'(m_entry_slot));
      check("cyc exit_ack",   32'(exit_ack),   32'(m_exit_ack));
      check("cyc exit_err",   32'(exit_err),   32'(m_exit_err));
      check("cyc elapsed",    32'(elapsed),    32'(m_elapsed));
      check("cyc occupied",   32'(occupied),   32'(exp_occ));
      check("cyc full",       32'(full),       32'(&exp_occ));
      check("cyc gate_open",  32'(gate_open),  32'(m_gate));
      check("cyc fee",        32'(fee),        32'(m_fee));
    end
  end

  task automatic tick();
    @(negedge clk);
    if (run_timer) timer = timer + TW'(1);
  endtask

  task automatic wait_resp(input string name);
    int n;
    bit got;
    n = 0;
    tick();
    while (!(entry_ack || entry_rej || exit_ack || exit_err) && n < 20) begin
      tick();
      n++;
    end
    got = entry_ack || entry_rej || exit_ack || exit_err;
    check({name, " response"}, 32'(got), 32'd1);
  endtask

  task automatic count_gate(input string name, input int exp);
    int g;
    g = 0;
    for (int i = 0; i < GATE_CYC + 2; i++) begin
      tick();
      if (gate_open) g++;
    end
    check({name, " gate cycles"}, 32'(g), 32'(exp));
  endtask

  task automatic do_entry(input string name, input bit exp_ack);
    entry_req = 1'b1;
    wait_resp(name);
    check({name, " entry_ack"}, 32'(entry_ack), 32'(exp_ack));
    check({name, " entry_rej"}, 32'(entry_rej), 32'(!exp_ack));
    entry_req = 1'b0;
    count_gate(name, exp_ack ? GATE_CYC : 0);
  endtask

  task automatic do_exit(input string name, input logic [3:0] slot, input bit exp_ack);
    exit_slot = slot;
    exit_req  = 1'b1;
    wait_resp(name);
    check({name, " exit_ack"}, 32'(exit_ack), 32'(exp_ack));
    check({name, " exit_err"}, 32'(exit_err), 32'(!exp_ack));
    exit_req = 1'b0;
    count_gate(name, exp_ack ? GATE_CYC : 0);
  endtask

  logic [15:0] fee_exp_36, fee_exp_200;

  initial begin
`ifdef PARK_FEE_EN
    fee_exp_36 = 16'd36; fee_exp_200 = 16'd200;
`else
    fee_exp_36 = 16'd0;  fee_exp_200 = 16'd0;
`endif
    rst_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 4'd0;
    timer = '0; run_timer = 1'b0;
    repeat (3) @(negedge clk);
    check("reset occupied",  32'(occupied),  32'd0);
    check("reset gate_open", 32'(gate_open), 32'd0);
    check("reset entry_slot", 32'(entry_slot), 32'd0);
    check("reset full",      32'(full),      32'd0);
    rst_n = 1'b1;
    tick();

    // First car at timer 5 gets slot 1.
    timer = TW'(5);
    do_entry("entry1", 1'b1);
    check("entry1 slot", 32'(entry_slot), 32'd1);
    check("entry1 occupied", 32'(occupied), 32'(6'b000001));
    timer = TW'(100);
    do_entry("entry2", 1'b1);
    timer = TW'(2040);
    do_entry("entry3", 1'b1);
    check("entry3 slot", 32'(entry_slot), 32'd3);
    run_timer = 1'b1;
    do_entry("entry4", 1'b1);
    do_entry("entry5", 1'b1);
    do_entry("entry6", 1'b1);
    check("lot full", 32'(full), 32'd1);

    // Seventh car is refused; slot and occupancy stay put.
    do_entry("entry7 rej", 1'b0);
    check("rej slot held", 32'(entry_slot), 32'd6);
    check("rej occupied", 32'(occupied), 32'(6'b111111));
    check("rej full", 32'(full), 32'd1);

    // Slot 3 leaves after the timer wrapped: (10 - 2040) mod 2048 = 18.
    run_timer = 1'b0;
    timer = TW'(10);
    do_exit("exit3 wrap", 4'd3, 1'b1);
    check("wrap elapsed", 32'(elapsed), 32'd18);
    check("wrap occupied", 32'(occupied), 32'(6'b111011));
    check("wrap fee", 32'(fee), 32'(fee_exp_36));
    do_entry("refill3", 1'b1);
    check("refill slot", 32'(entry_slot), 32'd3);

    // Both requests on a full lot: exit of slot 1 first, then the entry takes slot 1.
    exit_slot = 4'd1;
    exit_req  = 1'b1;
    entry_req = 1'b1;
    wait_resp("both exit");
    check("both exit first", 32'(exit_ack), 32'd1);
    check("both no entry yet", 32'(entry_ack), 32'd0);
    check("both exit elapsed", 32'(elapsed), 32'd5);
    exit_req = 1'b0;
    wait_resp("both entry");
    check("both entry ack", 32'(entry_ack), 32'd1);
    check("both entry slot", 32'(entry_slot), 32'd1);
    entry_req = 1'b0;
    count_gate("both entry", GATE_CYC);
    check("both occupied", 32'(occupied), 32'(6'b111111));

    // Release slot 4, then invalid or empty slot ids are all errors.
    run_timer = 1'b1;
    do_exit("exit4", 4'd4, 1'b1);
    do_exit("err slot0", 4'd0, 1'b0);
    do_exit("err slot7", 4'd7, 1'b0);
    do_exit("err slot4", 4'd4, 1'b0);
    do_exit("err slot15", 4'd15, 1'b0);
    check("err occupied", 32'(occupied), 32'(6'b110111));

    // Duration of 100 ticks.
    run_timer = 1'b0;
    timer = TW'(200);
    do_entry("fee entry", 1'b1);
    check("fee entry slot", 32'(entry_slot), 32'd4);
    timer = TW'(300);
    do_exit("fee exit", 4'd4, 1'b1);
    check("fee elapsed", 32'(elapsed), 32'd100);
    check("fee value", 32'(fee), 32'(fee_exp_200));

    // Reset in the middle of the gate pulse clears everything at once.
    entry_req = 1'b1;
    wait_resp("gate reset");
    entry_req = 1'b0;
    tick();
    check("gate open before reset", 32'(gate_open), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset gate_open", 32'(gate_open), 32'd0);
    check("reset occupied now", 32'(occupied), 32'd0);
    check("reset entry_ack", 32'(entry_ack), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (GATE_CYC + 3) tick();
    run_timer = 1'b1;
    do_entry("after reset", 1'b1);
    check("after reset slot", 32'(entry_slot), 32'd1);
    check("after reset occupied", 32'(occupied), 32'(6'b000001));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
